// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared PC constants, sequencer state encoding and sticky-flag helper.
package pc_sequencer_pkg;
  localparam int unsigned DEF_PC_SIZE   = 32;
  localparam int unsigned DEF_PC_STEP   = 4;
  localparam int unsigned DEF_RAS_DEPTH = 4;
  localparam int unsigned DEF_RESET_PC  = 0;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_END} state_t;
  // CLEAR helper: clear dominates set so a restart always begins with clean flags
  function automatic logic sticky_next(input logic flag, input logic set, input logic clear);
    return clear ? 1'b0 : (flag | set);
  endfunction
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_SIZE   = DEF_PC_SIZE,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [PC_SIZE-1:0] i_data,
  output logic [PC_SIZE-1:0] o_top,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_overflow,
  output logic               o_underflow
);
  localparam int unsigned AW = $clog2(RAS_DEPTH);
  logic [PC_SIZE-1:0] r_mem [RAS_DEPTH];
  logic [AW-1:0]      r_ptr;
  logic [AW:0]        r_count;
  logic [AW-1:0]      w_top_idx;
  logic               w_do_pop;
  logic               w_do_push;
  assign w_top_idx   = r_ptr - AW'(1);
  assign o_top       = r_mem[w_top_idx];
  assign o_full      = r_count == (AW+1)'(RAS_DEPTH);
  assign o_empty     = r_count == '0;
  assign w_do_pop    = i_pop & ~o_empty;
  assign w_do_push   = i_push & ~i_pop & ~i_clear;
  assign o_overflow  = w_do_push & o_full;
  assign o_underflow = i_pop & o_empty;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_pop) begin
      r_ptr   <= r_ptr - AW'(1);
      r_count <= r_count - (AW+1)'(1);
    end else if (w_do_push) begin
      r_ptr   <= r_ptr + AW'(1);
      r_count <= o_full ? r_count : r_count + (AW+1)'(1);
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_ptr] <= i_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter FSM with stall, halt, jump and call/return via pc_ras.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_SIZE   = DEF_PC_SIZE,
  parameter int unsigned PC_STEP   = DEF_PC_STEP,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH,
  parameter int unsigned RESET_PC  = DEF_RESET_PC
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic               i_halt,
  input  logic               i_enable,
  input  logic               i_not_load,
  input  logic               i_load,
  input  logic               i_call,
  input  logic               i_ret,
  input  logic [PC_SIZE-1:0] i_next_pc,
  output logic [PC_SIZE-1:0] o_pc,
  output logic               o_running,
  output logic               o_halted,
  output logic               o_ras_full,
  output logic               o_ras_empty,
  output logic               o_ras_overflow,
  output logic               o_ras_underflow
);
  localparam logic [PC_SIZE-1:0] W_RESET_PC = PC_SIZE'(RESET_PC);
  state_t             r_state, w_state_nx;
  logic [PC_SIZE-1:0] r_pc, w_pc_nx, w_pc_inc, w_ras_top;
  logic               r_ovf, r_unf;
  logic               w_push, w_pop, w_clear, w_flag_clr, w_ovf_pulse, w_unf_pulse;
  assign w_pc_inc = r_pc + PC_SIZE'(PC_STEP);
  pc_ras #(.PC_SIZE(PC_SIZE), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (w_pc_inc),
    .o_top       (w_ras_top),
    .o_full      (o_ras_full),
    .o_empty     (o_ras_empty),
    .o_overflow  (w_ovf_pulse),
    .o_underflow (w_unf_pulse)
  );
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_clear    = 1'b0;
    w_flag_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pc_nx    = W_RESET_PC;
        w_state_nx = i_start ? S_RUN : S_IDLE;
        w_flag_clr = i_start;
      end
      S_RUN: if (i_enable) begin
        if (i_halt) begin
          // PC parks at the reset value rather than advancing
          w_state_nx = S_END;
          w_pc_nx    = W_RESET_PC;
          w_clear    = 1'b1;
        end else if (i_not_load) begin
          w_state_nx = S_STALL;
        end else if (i_ret) begin
          w_pop   = 1'b1;
          w_pc_nx = o_ras_empty ? i_next_pc : w_ras_top;
        end else if (i_load) begin
          w_push  = i_call;
          w_pc_nx = i_next_pc;
        end else begin
          w_pc_nx = w_pc_inc;
        end
      end
      S_STALL: w_state_nx = S_RUN;
      default: begin
        w_pc_nx    = W_RESET_PC;
        w_clear    = 1'b1;
        w_state_nx = i_halt ? S_END : (i_start ? S_RUN : S_IDLE);
        w_flag_clr = ~i_halt & i_start;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= W_RESET_PC;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_ovf   <= sticky_next(r_ovf, w_ovf_pulse, w_flag_clr);
      r_unf   <= sticky_next(r_unf, w_unf_pulse, w_flag_clr);
    end
  end
  assign o_pc            = r_pc;
  assign o_running       = (r_state == S_RUN) | (r_state == S_STALL);
  assign o_halted        = r_state == S_END;
  assign o_ras_overflow  = r_ovf;
  assign o_ras_underflow = r_unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of sequencing, call/return stack, stall, halt and reset.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset_n, start, halt, enable, not_load, load, call, ret;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        running, halted, full, empty, ovf, unf;
  logic [7:0]  pc8;
  logic        running8, halted8, full8, empty8, ovf8, unf8;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  pc_sequencer dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_halt(halt), .i_enable(enable),
    .i_not_load(not_load), .i_load(load), .i_call(call), .i_ret(ret), .i_next_pc(next_pc),
    .o_pc(pc), .o_running(running), .o_halted(halted), .o_ras_full(full),
    .o_ras_empty(empty), .o_ras_overflow(ovf), .o_ras_underflow(unf)
  );
  pc_sequencer #(.PC_SIZE(8)) dut8 (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_halt(halt), .i_enable(enable),
    .i_not_load(not_load), .i_load(load), .i_call(call), .i_ret(ret), .i_next_pc(next_pc[7:0]),
    .o_pc(pc8), .o_running(running8), .o_halted(halted8), .o_ras_full(full8),
    .o_ras_empty(empty8), .o_ras_overflow(ovf8), .o_ras_underflow(unf8)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    {start, halt, not_load, load, call, ret} = '0;
  endtask
  initial begin
    logic [31:0] calls [5];
    logic [31:0] rets [5];
    calls = '{32'h200, 32'h300, 32'h400, 32'h500, 32'h600};
    rets  = '{32'h504, 32'h404, 32'h304, 32'h204, 32'hABC};
    reset_n = 1'b0; enable = 1'b0; next_pc = '0;
    idle_inputs();
    #12;
    check("rst_pc", pc, 0);
    check("rst_flags", {running, halted, full, empty, ovf, unf}, 6'b000100);
    reset_n = 1'b1;
    tick();
    check("idle_pc", pc, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_pc", pc, 0);
    check("start_run", running, 1);
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("inc", pc, 32'(4 * i));
      if (i == 3) begin
        enable = 1'b0;
        tick();
        check("en_hold", pc, 12);
        enable = 1'b1;
      end
    end
    load = 1'b1; call = 1'b1; next_pc = 32'h100;
    tick();
    check("call_pc", pc, 32'h100);
    check("call_nonempty", empty, 0);
    load = 1'b0; call = 1'b0;
    tick();
    check("after_call_inc", pc, 32'h104);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("ret_pc", pc, 32'h14);
    check("ret_empty", empty, 1);
    load = 1'b1; call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_pc = calls[i];
      tick();
      check("nest_pc", pc, calls[i]);
      if (i == 3) check("nest_full", {full, ovf}, 2'b10);
    end
    check("nest_ovf", {full, ovf}, 2'b11);
    load = 1'b0; call = 1'b0; ret = 1'b1; next_pc = 32'hABC;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("unwind_pc", pc, rets[i]);
      if (i == 3) check("unwind_empty_unf", {empty, unf}, 2'b10);
    end
    check("underflow", {empty, unf}, 2'b11);
    ret = 1'b0; call = 1'b1;
    tick();
    check("call_no_load_pc", pc, 32'hAC0);
    check("call_no_load_empty", empty, 1);
    load = 1'b1; next_pc = 32'h50;
    tick();
    check("push_again", pc, 32'h50);
    ret = 1'b1; next_pc = 32'h70;
    tick();
    idle_inputs();
    check("ret_beats_call_pc", pc, 32'hAC4);
    check("ret_beats_call_empty", empty, 1);
    not_load = 1'b1;
    tick();
    check("stall_pc", pc, 32'hAC4);
    check("stall_running", running, 1);
    not_load = 1'b0; load = 1'b1; next_pc = 32'h999;
    tick();
    load = 1'b0;
    check("stall_ignores", pc, 32'hAC4);
    tick();
    check("resume_inc", pc, 32'hAC8);
    halt = 1'b1;
    tick();
    check("halt_state", {halted, running}, 2'b10);
    check("halt_pc", pc, 0);
    tick();
    check("halt_stays", halted, 1);
    halt = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_run", {running, halted}, 2'b10);
    check("restart_flags", {ovf, unf}, 2'b00);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    check("end_to_idle", {running, halted}, 2'b00);
    start = 1'b1;
    tick();
    start = 1'b0; ret = 1'b1; next_pc = 32'hFC;
    tick();
    ret = 1'b0;
    check("w8_load", pc8, 8'hFC);
    check("w8_unf", unf8, 1);
    tick();
    check("w8_wrap", pc8, 8'h00);
    check("w32_nowrap", pc, 32'h100);
    load = 1'b1; call = 1'b1; next_pc = 32'h20;
    tick();
    idle_inputs();
    check("pre_stall_stack", empty, 0);
    not_load = 1'b1;
    tick();
    not_load = 1'b0;
    reset_n = 1'b0;
    #2;
    check("async_rst_pc", pc, 0);
    check("async_rst_flags", {running, halted, full, empty, ovf, unf}, 6'b000100);
    check("async_rst_w8", {pc8, running8, halted8, full8, empty8, ovf8, unf8}, 14'h0004);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_idle", {running, pc[7:0]}, 9'h000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
